bsc_axiu_interleave_ar_splitter: RTL

AXI read-path controller placed in front of the DDR bank address interleaver. It accepts INCR read bursts from an accelerator-side master and splits each burst at STRIDE boundaries, so every sub-burst maps to exactly one bank. Each sub-burst is issued downstream with its interleaved address. On the R channel it passes data through and suppresses RLAST on all but the final sub-burst of each original burst.

---
 rtl/bsc_axiu_interleave_pkg.sv | 35 +++
 rtl/bsc_axiu_split_flag_fifo.sv | 65 ++++++
 rtl/bsc_axiu_interleave_ar_splitter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bsc_axiu_interleave_pkg.sv
// Shared definitions for the interleaved AR splitter: address width, splitter FSM states
// and the bank address interleave function applied to every downstream read address.
package bsc_axiu_interleave_pkg;

    localparam int ADDR_WIDTH = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] low_mask(input int unsigned bits);
        return ~({ADDR_WIDTH{1'b1}} << bits);
    endfunction

    // Moves the bank-select bits (just above the stride offset) to the top of the bank field:
    // out = {in[AW-1:D+N], in[S+N-1:S], in[D+N-1:S+N], in[S-1:0]}
    function automatic logic [ADDR_WIDTH-1:0] interleave_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input int unsigned           s_bits,
        input int unsigned           n_bits,
        input int unsigned           d_bits
    );
        logic [ADDR_WIDTH-1:0] w_low;
        logic [ADDR_WIDTH-1:0] w_bank;
        logic [ADDR_WIDTH-1:0] w_mid;
        logic [ADDR_WIDTH-1:0] w_high;
        w_low  = addr & low_mask(s_bits);
        w_bank = (addr >> s_bits) & low_mask(n_bits);
        w_mid  = (addr >> (s_bits + n_bits)) & low_mask(d_bits - s_bits);
        w_high = addr & ~low_mask(d_bits + n_bits);
        return w_high | (w_bank << d_bits) | (w_mid << s_bits) | w_low;
    endfunction

endpackage

// File: rtl/bsc_axiu_split_flag_fifo.sv
// One-bit synchronous FIFO holding the "final sub-burst" flag of every issued sub-burst,
// in issue order, so the R path knows which RLAST to forward upstream.
module bsc_axiu_split_flag_fifo #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_din,
    output logic             o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & (r_count != '0);

    always_comb begin
        // NOTE: default assignment first so every path drives w_count_nxt and no latch is inferred.
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/bsc_axiu_interleave_ar_splitter.sv
// AXI read splitter in front of the bank interleaver: cuts INCR bursts at STRIDE granules so each
// sub-burst maps to one bank, and forwards RLAST only for the final sub-burst of each burst.
module bsc_axiu_interleave_ar_splitter #(
    parameter int          ADDR_WIDTH      = 64,
    parameter int          ID_WIDTH        = 6,
    parameter int          DATA_BYTES      = 64,
    parameter int          NUM_BANKS       = 4,
    parameter logic [63:0] STRIDE          = 64'h400,
    parameter logic [63:0] BANK_SIZE       = 64'h4_0000_0000,
    parameter int          MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [8*DATA_BYTES-1:0] m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [8*DATA_BYTES-1:0] s_rdata,
    output logic [1:0]              s_rresp,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    err
);

    import bsc_axiu_interleave_pkg::*;

    localparam int          PKG_AW = bsc_axiu_interleave_pkg::ADDR_WIDTH;
    localparam int unsigned B_BITS = $clog2(DATA_BYTES);
    localparam int unsigned S_BITS = $clog2(STRIDE);
    localparam int unsigned N_BITS = $clog2(NUM_BANKS);
    localparam int unsigned D_BITS = $clog2(BANK_SIZE);
    localparam int          CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_M = ADDR_WIDTH'(STRIDE - 64'd1);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [8:0]            r_beats_left;
    logic [ID_WIDTH-1:0]   r_cur_id;
    logic                  r_err;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_fifo_head;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [ADDR_WIDTH-1:0] w_to_bnd;
    logic                  w_last;
    logic [8:0]            w_sub_beats;
    logic                  w_s_ar_fire;
    logic                  w_m_ar_fire;
    logic                  w_r_last_fire;

    // Beats left before the current address crosses into the next stride granule (next bank).
    assign w_to_bnd    = (STRIDE_A - (r_cur_addr & STRIDE_M)) >> B_BITS;
    assign w_last      = {{(ADDR_WIDTH-9){1'b0}}, r_beats_left} <= w_to_bnd;
    assign w_sub_beats = w_last ? r_beats_left : w_to_bnd[8:0];

    // r_cur_id doubles as the last accepted ID: only one ID may be in flight at a time.
    assign s_arready = ~rst & (r_state == IDLE) & ~w_fifo_full
                     & ((w_fifo_count == '0) | (s_arid == r_cur_id));
    assign m_arvalid = (r_state == SPLIT) & ~w_fifo_full;
    assign m_araddr  = ADDR_WIDTH'(interleave_addr(PKG_AW'(r_cur_addr), S_BITS, N_BITS, D_BITS));
    assign m_arlen   = w_sub_beats[7:0] - 8'd1;
    assign m_arid    = r_cur_id;

    assign w_s_ar_fire = s_arvalid & s_arready;
    assign w_m_ar_fire = m_arvalid & m_arready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_cur_id     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_s_ar_fire) begin
                        r_cur_addr   <= s_araddr;
                        r_beats_left <= {1'b0, s_arlen} + 9'd1;
                        r_cur_id     <= s_arid;
                        r_state      <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (w_m_ar_fire) begin
                        r_cur_addr   <= r_cur_addr + ({{(ADDR_WIDTH-9){1'b0}}, w_sub_beats} << B_BITS);
                        r_beats_left <= r_beats_left - w_sub_beats;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_rready      = s_rready;
    assign s_rdata       = m_rdata;
    assign s_rresp       = m_rresp;
    assign s_rid         = m_rid;
    assign s_rvalid      = m_rvalid;
    assign s_rlast       = m_rlast & ~w_fifo_empty & w_fifo_head;
    assign w_r_last_fire = m_rvalid & s_rready & m_rlast;

    // An RLAST with no sub-burst on record belongs to nothing we issued (e.g. pre-reset traffic).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_r_last_fire && w_fifo_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    bsc_axiu_split_flag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_flag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_m_ar_fire),
        .i_pop   (w_r_last_fire),
        .i_din   (w_last),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule
